// File: rtl/ps2_host_tx_pkg.sv
// Shared definitions for the PS/2 host transmit path: SPAM widths and device id,
// controller state encoding, status word layout and default timing.
package ps2_host_tx_pkg;

  localparam int unsigned SPAM_DID_HI  = 3;
  localparam int unsigned SPAM_ADDR_HI = 23;
  localparam int unsigned SPAM_DATA_HI = 31;
  localparam logic [SPAM_DID_HI:0] SPAM_DID_KBDCTL = 4'h5;

  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 500000;

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SEND, S_ACK, S_RELEASE
  } state_t;

  // Status word as seen by a SPAM read; field order fixes the bit positions.
  typedef struct packed {
    logic [15:0] rsvd_hi;
    logic [7:0]  cmd;
    logic [1:0]  retry;
    logic        rsvd5;
    logic        overrun;
    logic        timeout;
    logic        nak;
    logic        ok;
    logic        busy;
  } status_t;

  // Frame bit n after the start bit: data LSB first, odd parity, then stop.
  function automatic logic frame_bit(input logic [7:0] cmd, input logic [3:0] n);
    if (n < 4'd8)       return cmd[n[2:0]];
    else if (n == 4'd8) return ~^cmd;
    else                return 1'b1;
  endfunction

endpackage

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchronizers for the PS/2 clock and data pads plus ps2clk falling-edge
// detection; shared with the keyboard receiver.
module ps2_line_sync (
  input  logic cclk,
  input  logic cclk_rst_b,
  input  logic ps2clk_in,
  input  logic ps2data_in,
  output logic clk_s,
  output logic data_s,
  output logic clk_fall_c
);

  logic [1:0] clk_q;
  logic [1:0] data_q;
  logic       clk_prev;

  // Idle bus level is high, so reset to 1 to avoid a spurious edge.
  always_ff @(posedge cclk or negedge cclk_rst_b) begin
    if (!cclk_rst_b) begin
      clk_q    <= 2'b11;
      data_q   <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_q    <= {clk_q[0], ps2clk_in};
      data_q   <= {data_q[0], ps2data_in};
      clk_prev <= clk_q[1];
    end
  end

  assign clk_s      = clk_q[1];
  assign data_s     = data_q[1];
  assign clk_fall_c = clk_prev & ~clk_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with SPAM command/status access.
// Define PS2_TX_RETRY_EN to retry NAKed or timed-out transfers up to 3 times.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter logic [SPAM_ADDR_HI:0] SPAM_ADDRPFX   = 24'h000000,
  parameter logic [SPAM_ADDR_HI:0] SPAM_ADDRMASK  = 24'h000000,
  parameter int unsigned           INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned           TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                    cclk,
  input  logic                    cclk_rst_b,
  input  logic                    ps2clk_in,
  input  logic                    ps2data_in,
  output logic                    ps2clk_oe,
  output logic                    ps2data_oe,
  output logic                    rx_inhibit,
  input  logic                    spamo_valid,
  input  logic                    spamo_r_nw,
  input  logic [SPAM_DID_HI:0]    spamo_did,
  input  logic [SPAM_ADDR_HI:0]   spamo_addr,
  input  logic [SPAM_DATA_HI:0]   spamo_data,
  output logic                    ps2tx__spami_busy_b,
  output logic [SPAM_DATA_HI:0]   ps2tx__spami_data
);

  localparam int unsigned CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                      : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [3:0]         bit_idx;
  logic [7:0]         cmd;
  logic               st_ok, st_nak, st_to, st_ov;
  logic [1:0]         retry;
  logic               nak_retry;
  logic               clk_s, data_s, clk_fall_c;
  logic               decode_c, wr_c, rd_c;
  logic               progress_c, give_up_c, retry_ok_c;
  status_t            status_c;
  logic               unused_spam_data;

  ps2_line_sync u_sync (
    .cclk       (cclk),
    .cclk_rst_b (cclk_rst_b),
    .ps2clk_in  (ps2clk_in),
    .ps2data_in (ps2data_in),
    .clk_s      (clk_s),
    .data_s     (data_s),
    .clk_fall_c (clk_fall_c)
  );

`ifdef PS2_TX_RETRY_EN
  localparam logic [1:0] MAX_RETRIES = 2'd3;
  assign retry_ok_c = (retry != MAX_RETRIES);
`else
  assign retry_ok_c = 1'b0;
`endif

  assign decode_c = spamo_valid && (spamo_did == SPAM_DID_KBDCTL) &&
                    ((spamo_addr & SPAM_ADDRMASK) == SPAM_ADDRPFX);
  assign wr_c     = decode_c & ~spamo_r_nw;
  assign rd_c     = decode_c &  spamo_r_nw;
  assign unused_spam_data = ^spamo_data[SPAM_DATA_HI:8];

  // A wait is satisfied by a device edge, or by both lines idle while releasing.
  assign progress_c = (state == S_RELEASE) ? (clk_s & data_s) : clk_fall_c;
  assign give_up_c  = (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) && !progress_c &&
                      (state == S_SEND || state == S_ACK || state == S_RELEASE);

  always_comb begin
    status_c         = '0;
    status_c.busy    = (state != S_IDLE);
    status_c.ok      = st_ok;
    status_c.nak     = st_nak;
    status_c.timeout = st_to;
    status_c.overrun = st_ov;
    status_c.retry   = retry;
    status_c.cmd     = cmd;
  end

  always_ff @(posedge cclk or negedge cclk_rst_b) begin
    if (!cclk_rst_b) begin
      state               <= S_IDLE;
      cnt                 <= '0;
      bit_idx             <= '0;
      cmd                 <= '0;
      st_ok               <= 1'b0;
      st_nak              <= 1'b0;
      st_to               <= 1'b0;
      st_ov               <= 1'b0;
      retry               <= '0;
      nak_retry           <= 1'b0;
      ps2clk_oe           <= 1'b0;
      ps2data_oe          <= 1'b0;
      rx_inhibit          <= 1'b0;
      ps2tx__spami_busy_b <= 1'b0;
      ps2tx__spami_data   <= '0;
    end else begin
      ps2tx__spami_busy_b <= decode_c;
      ps2tx__spami_data   <= rd_c ? status_c : '0;
      cnt                 <= cnt + 1'b1;

      // Read-clear comes first so same-cycle events below survive it.
      if (rd_c) begin
        st_ok  <= 1'b0;
        st_nak <= 1'b0;
        st_to  <= 1'b0;
        st_ov  <= 1'b0;
      end
      if (wr_c && state != S_IDLE) st_ov <= 1'b1;

      case (state)
        S_IDLE: begin
          ps2clk_oe  <= 1'b0;
          ps2data_oe <= 1'b0;
          rx_inhibit <= 1'b0;
          if (wr_c) begin
            cmd        <= spamo_data[7:0];
            st_ok      <= 1'b0;
            st_nak     <= 1'b0;
            st_to      <= 1'b0;
            retry      <= '0;
            nak_retry  <= 1'b0;
            cnt        <= '0;
            state      <= S_INHIBIT;
            ps2clk_oe  <= 1'b1;
            rx_inhibit <= 1'b1;
          end
        end
        S_INHIBIT: begin
          if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
            cnt        <= '0;
            state      <= S_REQ;
            ps2clk_oe  <= 1'b0;
            ps2data_oe <= 1'b1;
          end
        end
        S_REQ: begin
          cnt     <= '0;
          bit_idx <= '0;
          state   <= S_SEND;
        end
        S_SEND: begin
          if (clk_fall_c) begin
            cnt        <= '0;
            ps2data_oe <= ~frame_bit(cmd, bit_idx);
            if (bit_idx == 4'd9) state   <= S_ACK;
            else                 bit_idx <= bit_idx + 1'b1;
          end
        end
        S_ACK: begin
          if (clk_fall_c) begin
            cnt   <= '0;
            state <= S_RELEASE;
            if (!data_s)         st_ok     <= 1'b1;
            else if (retry_ok_c) nak_retry <= 1'b1;
            else                 st_nak    <= 1'b1;
          end
        end
        S_RELEASE: begin
          if (clk_s && data_s) begin
            cnt <= '0;
            if (nak_retry) begin
              nak_retry <= 1'b0;
              retry     <= retry + 2'd1;
              ps2clk_oe <= 1'b1;
              state     <= S_INHIBIT;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Device stopped answering: drop both lines, then retry or give up.
      if (give_up_c) begin
        cnt        <= '0;
        ps2data_oe <= 1'b0;
        nak_retry  <= 1'b0;
        if (retry_ok_c) begin
          retry     <= retry + 2'd1;
          ps2clk_oe <= 1'b1;
          state     <= S_INHIBIT;
        end else begin
          st_to     <= 1'b1;
          ps2clk_oe <= 1'b0;
          state     <= S_IDLE;
        end
      end
    end
  end

endmodule

// File: doc/ps2_host_tx.md
# ps2_host_tx

Host-to-device command controller for the PS/2 keyboard port. It accepts a command byte over SPAM, inhibits the bus, and shifts the byte out on the device-generated clock. It then checks the line-level ACK and reports the outcome through a SPAM-readable status register. It shares the open-drain ps2clk/ps2data pair with the existing keyboard receiver and masks that receiver for the duration of a transmission.

## Interface
- SPAM_ADDRPFX, 24'h000000, address prefix matched under mask
- SPAM_ADDRMASK, 24'h000000, address decode mask
- INHIBIT_CYCLES, 5000, cclk cycles ps2clk is held low before request (≥100 µs)
- TIMEOUT_CYCLES, 500000, maximum cclk cycles spent waiting on any single device edge
- cclk  in  1  core clock
- cclk_rst_b  in  1  reset, asynchronous, active-low
- ps2clk_in  in  1  raw ps2clk pad input (asynchronous)
- ps2data_in  in  1  raw ps2data pad input (asynchronous)
- ps2clk_oe  out  1  1 = drive ps2clk low; 0 = release
- ps2data_oe  out  1  1 = drive ps2data low; 0 = release
- rx_inhibit  out  1  1 = receiver must discard bits and reset its bit counter
- spamo_valid, spamo_r_nw, spamo_did, spamo_addr, spamo_data  in  1/1/SPAM_DID_HI+1/SPAM_ADDR_HI+1/SPAM_DATA_HI+1  SPAM request
- ps2tx__spami_busy_b  out  1  response strobe, one cycle after a decoded access
- ps2tx__spami_data  out  SPAM_DATA_HI+1  read data; 0 when not responding

## Operation
- Decode: spamo_valid && did==SPAM_DID_KBDCTL && (addr & MASK)==PFX.
  - Write: loads spamo_data[7:0] as the command.
  - Read: returns status.
- Status word:
  - [0] busy
  - [1] ok
  - [2] nak
  - [3] timeout
  - [4] overrun
  - [15:8] last command
  - others 0
  - A read clears [4:1] after returning them.
- A write while busy is dropped and sets overrun. A write while idle starts a transfer and clears [3:1].
- ps2clk_in and ps2data_in each pass through a 2-flop synchronizer. Falling edge means previous synced = 1 and current synced = 0.
- Parity is odd: ~^cmd.
- FSM:
  - IDLE: all oe = 0, rx_inhibit = 0.
  - INHIBIT: ps2clk_oe = 1 for INHIBIT_CYCLES.
  - REQ: ps2data_oe = 1 (start bit), ps2clk_oe = 0. Go to SEND.
  - SEND: bit index n = 0..9. On each falling edge, drive bit n:
    - n 0–7: cmd[n]
    - n 8: parity
    - n 9: stop, released
    - ps2data_oe = ~bit.
    - After the 10th edge, go to ACK.
  - ACK: on the next falling edge, sample ps2data. 0 sets ok, 1 sets nak. Go to RELEASE.
  - RELEASE: wait until synced clk and data are both 1. Go to IDLE and clear busy.
- Timeout: a wait counter reloads on every state change and every falling edge. Reaching TIMEOUT_CYCLES in SEND, ACK, or RELEASE sets timeout, releases both lines, and returns to IDLE.
- rx_inhibit = 1 in every state except IDLE, and stays 1 for one extra cycle after returning to IDLE.

## Timing
- Reset: FSM = IDLE; ps2clk_oe, ps2data_oe, and rx_inhibit = 0; status = 0; ps2tx__spami_busy_b = 0; ps2tx__spami_data = 0.
- The write is accepted on the decode cycle. ps2tx__spami_busy_b pulses 1 in the next cycle for both reads and writes.
- The next cycle after an accepted write: busy = 1, ps2clk_oe = 1.
- INHIBIT lasts exactly INHIBIT_CYCLES cycles. ps2data_oe asserts in the cycle ps2clk_oe deasserts.
- Data updates 3 cycles after the pad falling edge: 2 synchronizer stages plus edge register.
- Read concurrent with a status-setting event: the read returns the pre-event value, and the event bit survives the clear.
- Reset mid-transfer: both lines are released immediately (asynchronous) and no status is retained.

## Configuration
- PS2_TX_RETRY_EN defined:
  - nak or timeout re-enters INHIBIT, up to 3 retries.
  - Status [7:6] holds the retry count used.
  - nak/timeout are set only after the final attempt fails.
- Undefined: single attempt; [7:6] read 0.

## Structure
- Add SPAM_DID_KBDCTL to spam_defines.vh.
- Shared package holds:
  - FSM state encoding (IDLE, INHIBIT, REQ, SEND, ACK, RELEASE)
  - status bit positions
  - default INHIBIT_CYCLES and TIMEOUT_CYCLES
- One sub-module: ps2_line_sync. It holds the 2-flop synchronizers for clk and data plus falling-edge detection, so the receiver can reuse it.

## Test plan
- Idle write 0xED with a device model that ACKs:
  - Device samples start bit 0, bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Status read returns 0x0000ED02, then 0x0000ED00.
- Device answers ACK bit = 1 → status 0x0000ED04.
- Device never clocks after REQ → after TIMEOUT_CYCLES, timeout is set (0x...08), both oe = 0, rx_inhibit falls.
- Write 0xFF while busy → transfer of 0xED unaffected; overrun bit set. Read returns bit4 = 1 and bit1 = 1.
- Assert cclk_rst_b = 0 during SEND bit 4 → ps2clk_oe = ps2data_oe = 0 in the same cycle; status reads 0 after reset.
- PS2_TX_RETRY_EN, device NAKs twice then ACKs → three INHIBIT phases observed; status ok with [7:6] = 2.
